// File: rtl/c432_lock_pkg.sv
// c432_lock_pkg: shared widths, tap positions and FSM states for the c432 key sequencer
//   KEY_W/BEAT_W/N_BEATS - MUX-lock key p1..p20 loaded as five 4-bit beats
//   IN_W/OUT_W           - c432 core primary input / output widths
//   SIG_W                - MISR signature width
//   LFSR_TAP_*           - pattern LFSR feedback taps
//   MISR_TAP_*           - response MISR feedback taps
package c432_lock_pkg;
   localparam int KEY_W      = 20;
   localparam int BEAT_W     = 4;
   localparam int N_BEATS    = 5;
   localparam int IN_W       = 36;
   localparam int OUT_W      = 7;
   localparam int SIG_W      = 16;
   localparam int LFSR_TAP_A = 35;
   localparam int LFSR_TAP_B = 24;
   localparam int MISR_TAP_A = 15;
   localparam int MISR_TAP_B = 14;
   localparam int MISR_TAP_C = 12;
   localparam int MISR_TAP_D = 3;
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_APPLY, S_WAIT, S_CAPTURE, S_CHECK, S_UNLOCKED, S_LOCKOUT
   } state_t;
endpackage

// File: rtl/c432_misr_lfsr.sv
// c432_misr_lfsr: pattern LFSR and response MISR for the c432 lock self-test
//   clk, rst - clock, asynchronous active-high reset (LFSR = SEED, MISR = 0)
//   load     - reseed the LFSR and clear the MISR
//   step     - advance the LFSR and fold resp into the MISR
//   resp     - core response captured on step
//   pattern  - current LFSR value, applied to the core inputs
//   sig      - accumulated MISR signature
module c432_misr_lfsr
   import c432_lock_pkg::*;
#(
   parameter logic [IN_W-1:0] SEED = 36'h1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [OUT_W-1:0] resp,
   output logic [IN_W-1:0]  pattern,
   output logic [SIG_W-1:0] sig
);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pattern <= SEED;
         sig     <= '0;
      end else if (load) begin
         pattern <= SEED;
         sig     <= '0;
      end else if (step) begin
         pattern <= {pattern[IN_W-2:0], pattern[LFSR_TAP_A] ^ pattern[LFSR_TAP_B]};
         sig     <= {sig[SIG_W-2:0], sig[MISR_TAP_A] ^ sig[MISR_TAP_B] ^ sig[MISR_TAP_C] ^ sig[MISR_TAP_D]}
                    ^ SIG_W'(resp);
      end
endmodule

// File: rtl/c432_key_sequencer.sv
// c432_key_sequencer: loads the 20-bit MUX-lock key, self-tests the locked c432 core and gates its outputs
//   key_in/key_valid/key_ready - 4-bit key beats, beat n -> key[4n+3:4n]
//   func_in/func_out           - functional traffic; func_out is live only once unlocked
//   core_in/core_out/core_key  - connection to the combinational locked core
//   busy      - self-test (APPLY..CHECK) in progress
//   unlocked  - signature matched, traffic passes through until reset
//   lockout   - MAX_FAIL bad attempts reached, permanent until reset
//   fail_cnt  - failed attempts since reset (saturates at 7)
module c432_key_sequencer
   import c432_lock_pkg::*;
#(
   parameter int              N_PAT      = 16,
   parameter int              SETTLE     = 2,
   parameter logic [SIG_W-1:0] GOLDEN_SIG = 16'h0000,
   parameter int              MAX_FAIL   = 3,
   parameter logic [IN_W-1:0] LFSR_SEED  = 36'h0_0000_0001
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BEAT_W-1:0] key_in,
   input  logic              key_valid,
   output logic              key_ready,
   input  logic [IN_W-1:0]   func_in,
   output logic [OUT_W-1:0]  func_out,
   output logic [IN_W-1:0]   core_in,
   input  logic [OUT_W-1:0]  core_out,
   output logic [KEY_W-1:0]  core_key,
   output logic              busy,
   output logic              unlocked,
   output logic              lockout,
   output logic [2:0]        fail_cnt
);
   state_t state, nxt;
   logic [KEY_W-1:0] key;
   logic [2:0] beat_cnt, fail_new;
   logic [3:0] wait_cnt;
   logic [7:0] pat_cnt;
   logic [IN_W-1:0] pattern;
   logic [SIG_W-1:0] sig;
   logic testing, xfer, load, step, match, last_pat;

   c432_misr_lfsr #(.SEED(LFSR_SEED)) u_misr_lfsr (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .step    (step),
      .resp    (core_out),
      .pattern (pattern),
      .sig     (sig)
   );

   assign testing   = state inside {S_APPLY, S_WAIT, S_CAPTURE};
   // key_ready is gated by rst so it drops to its reset value while reset is held
   assign key_ready = !rst && (state inside {S_IDLE, S_LOAD});
   assign xfer      = key_valid && key_ready;
   assign load      = xfer && beat_cnt == 3'(N_BEATS - 1);
   assign step      = state == S_CAPTURE;
   assign last_pat  = pat_cnt + 8'd1 == 8'(N_PAT);
   assign match     = sig == GOLDEN_SIG;
   assign fail_new  = fail_cnt == 3'd7 ? fail_cnt : fail_cnt + 3'd1;
   assign busy      = testing || state == S_CHECK;
   assign unlocked  = state == S_UNLOCKED;
   assign lockout   = state == S_LOCKOUT;
   assign core_in   = testing ? pattern : func_in;
   assign core_key  = lockout ? '0 : key;
   assign func_out  = unlocked ? core_out : '0;

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:    nxt = xfer ? S_LOAD : S_IDLE;
         S_LOAD:    nxt = load ? S_APPLY : S_LOAD;
         S_APPLY:   nxt = SETTLE == 1 ? S_CAPTURE : S_WAIT;
         // wait_cnt reaches 0 on the transition out of WAIT
         S_WAIT:    nxt = wait_cnt <= 4'd1 ? S_CAPTURE : S_WAIT;
         S_CAPTURE: nxt = last_pat ? S_CHECK : S_APPLY;
         S_CHECK:   nxt = match ? S_UNLOCKED : fail_new >= 3'(MAX_FAIL) ? S_LOCKOUT : S_IDLE;
         default:   nxt = state;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= S_IDLE;
         key      <= '0;
         beat_cnt <= '0;
         wait_cnt <= '0;
         pat_cnt  <= '0;
         fail_cnt <= '0;
      end else begin
         state <= nxt;
         if (xfer) begin
            key[beat_cnt*BEAT_W +: BEAT_W] <= key_in;
            beat_cnt                       <= beat_cnt + 3'd1;
         end
         if (load) pat_cnt <= '0;
         if (step) pat_cnt <= pat_cnt + 8'd1;
         if (state == S_APPLY) wait_cnt <= 4'(SETTLE - 1);
         if (state == S_WAIT) wait_cnt <= wait_cnt - 4'd1;
         if (state == S_CHECK && !match) begin
            fail_cnt <= fail_new;
            if (nxt == S_IDLE) begin
               key      <= '0;
               beat_cnt <= '0;
            end
         end
      end
endmodule

// File: tb/tb_c432_key_sequencer.sv
// tb_c432_key_sequencer: directed self-checking bench for c432_key_sequencer with a stand-in locked core
module tb_c432_key_sequencer;
   localparam logic [35:0] SEED = 36'h0_0000_0001;
   localparam logic [19:0] KEY  = 20'h54321;

   // stand-in core: wrong key bits corrupt the outputs
   function automatic logic [6:0] core_fn(input logic [35:0] x, input logic [19:0] k);
      logic [19:0] d;
      d = k ^ KEY;
      return x[6:0] ^ x[35:29] ^ d[6:0] ^ d[13:7] ^ {1'b0, d[19:14]};
   endfunction

   function automatic logic [15:0] model_sig(input logic [19:0] k);
      logic [35:0] l;
      logic [15:0] m;
      l = SEED;
      m = '0;
      for (int i = 0; i < 16; i++) begin
         m = {m[14:0], m[15] ^ m[14] ^ m[12] ^ m[3]} ^ {9'b0, core_fn(l, k)};
         l = {l[34:0], l[35] ^ l[24]};
      end
      return m;
   endfunction

   localparam logic [15:0] GOLD = model_sig(KEY);

   logic        clk = 1'b0, rst = 1'b0, key_valid = 1'b0;
   logic [3:0]  key_in = '0;
   logic [35:0] func_in = 36'h9_ABCD_1234, core_in;
   logic [6:0]  func_out, core_out;
   logic [19:0] core_key;
   logic        key_ready, busy, unlocked, lockout;
   logic [2:0]  fail_cnt;
   int checks = 0, failures = 0;

   c432_key_sequencer #(
      .N_PAT(16), .SETTLE(2), .GOLDEN_SIG(GOLD), .MAX_FAIL(3), .LFSR_SEED(SEED)
   ) dut (
      .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
      .func_in(func_in), .func_out(func_out), .core_in(core_in), .core_out(core_out),
      .core_key(core_key), .busy(busy), .unlocked(unlocked), .lockout(lockout), .fail_cnt(fail_cnt)
   );

   assign core_out = core_fn(core_in, core_key);
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(1);
   endtask

   // returns at the first negedge after the last beat transfer (cycle 1 of the test)
   task automatic send_key(input logic [19:0] k, input int gap);
      for (int b = 0; b < 5; b++) begin
         key_in    = k[4*b +: 4];
         key_valid = 1'b1;
         @(negedge clk);
         if (b == 1 && gap > 0) begin
            key_valid = 1'b0;
            cyc(gap);
            chk("gap_ready", key_ready, 1);
            chk("gap_busy", busy, 0);
            chk("gap_key", core_key, {12'h0, k[7:0]});
         end
      end
      key_valid = 1'b0;
   endtask

   initial begin
      #1 rst = 1'b1;
      #2;
      chk("rst_ready", key_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_unlocked", unlocked, 0);
      chk("rst_lockout", lockout, 0);
      chk("rst_func_out", func_out, 0);
      chk("rst_core_key", core_key, 0);
      chk("rst_core_in", core_in, 36'h9_ABCD_1234);
      chk("rst_fail", fail_cnt, 0);
      cyc(2);
      rst = 1'b0;
      cyc(1);
      chk("idle_ready", key_ready, 1);

      // correct key, contiguous beats
      send_key(KEY, 0);
      chk("t1_key", core_key, KEY);
      chk("t1_busy1", busy, 1);
      chk("t1_core_in_seed", core_in, SEED);
      chk("t1_ready_busy", key_ready, 0);
      cyc(48);
      chk("t1_busy49", busy, 1);
      chk("t1_unl49", unlocked, 0);
      cyc(1);
      chk("t1_unl50", unlocked, 1);
      chk("t1_busy50", busy, 0);
      chk("t1_fail", fail_cnt, 0);
      chk("t1_ready_unl", key_ready, 0);
      func_in = 36'h0_0000_007F;
      #1 chk("t1_func_7f", func_out, 7'h7F);
      func_in = 36'h5_A5A5_A5A5;
      #1 chk("t1_func_a5", func_out, core_fn(36'h5_A5A5_A5A5, KEY));
      func_in = 36'hC_0000_0000;
      #1 chk("t1_func_top", func_out, 7'h60);
      cyc(5);
      chk("t1_unl_hold", unlocked, 1);

      // wrong key, then gapped correct key
      do_reset();
      func_in = 36'h3_1415_9265;
      send_key(20'h00000, 0);
      cyc(49);
      chk("t2_fail1", fail_cnt, 1);
      chk("t2_ready", key_ready, 1);
      chk("t2_unl", unlocked, 0);
      chk("t2_busy", busy, 0);
      chk("t2_key_clr", core_key, 0);
      send_key(KEY, 10);
      chk("t2_key", core_key, KEY);
      chk("t2_busy_start", busy, 1);
      cyc(49);
      chk("t2_unl", unlocked, 1);
      chk("t2_fail_hold", fail_cnt, 1);

      // async reset mid-WAIT of pattern 7
      do_reset();
      send_key(20'h00000, 0);
      cyc(49);
      chk("t3_fail_pre", fail_cnt, 1);
      send_key(KEY, 0);
      cyc(19);
      chk("t3_wait_busy", busy, 1);
      chk("t3_pat7", core_in, 36'h0_0000_0040);
      func_in = 36'h1_2345_6789;
      rst = 1'b1;
      #1;
      chk("t3_rst_busy", busy, 0);
      chk("t3_rst_ready", key_ready, 0);
      chk("t3_rst_core_in", core_in, 36'h1_2345_6789);
      chk("t3_rst_key", core_key, 0);
      chk("t3_rst_fail", fail_cnt, 0);
      chk("t3_rst_func", func_out, 0);
      cyc(1);
      rst = 1'b0;
      cyc(1);
      chk("t3_idle_ready", key_ready, 1);
      chk("t3_fail0", fail_cnt, 0);

      // key_valid held through the test, then lockout
      do_reset();
      send_key(20'h99999, 0);
      key_valid = 1'b1;
      key_in    = 4'hA;
      cyc(24);
      chk("t4_key_mid", core_key, 20'h99999);
      chk("t4_ready_mid", key_ready, 0);
      cyc(24);
      chk("t4_key_check", core_key, 20'h99999);
      chk("t4_busy_check", busy, 1);
      cyc(1);
      chk("t4_no_beat", core_key, 0);
      chk("t4_idle_ready", key_ready, 1);
      chk("t4_fail1", fail_cnt, 1);
      key_valid = 1'b0;
      send_key(20'h00000, 0);
      cyc(49);
      chk("t4_fail2", fail_cnt, 2);
      send_key(20'h99999, 0);
      cyc(49);
      chk("t4_lockout", lockout, 1);
      chk("t4_fail3", fail_cnt, 3);
      chk("t4_lk_key", core_key, 0);
      chk("t4_lk_func", func_out, 0);
      chk("t4_lk_ready", key_ready, 0);
      chk("t4_lk_busy", busy, 0);
      send_key(KEY, 0);
      cyc(60);
      chk("t4_lk_stay", lockout, 1);
      chk("t4_lk_unl", unlocked, 0);
      chk("t4_lk_key2", core_key, 0);
      chk("t4_lk_busy2", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
